// File: rtl/reg_seq_pkg.sv
// Shared encodings for the lab register command sequencer: FSM states and
// seven-segment constants (active-low, bit order {g,f,e,d,c,b,a}).
package reg_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StSave,
    StShow,
    StGap
  } seq_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index 0 is the first element of the list.
  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex digit to active-low seven-segment decode.
module hex_to_7seg
  import reg_seq_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/reg_cmd_sequencer.sv
// Orders button requests into spaced datapath strobes and multiplexes d_out onto a 2-digit display.
// Optional executed-command counter on cmd_count when CMD_COUNT_EN is defined.
module reg_cmd_sequencer
  import reg_seq_pkg::*;
#(
  parameter int unsigned DW       = 8,
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned CMD_GAP  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          write_btn,
  input  logic          save_btn,
  input  logic          show_btn,
  input  logic [DW-1:0] d_in,
  input  logic [DW-1:0] dp_d_out,
  output logic          dp_write_en,
  output logic          dp_save_data,
  output logic          dp_show_reg,
  output logic [DW-1:0] dp_d_in,
  output logic          busy,
  output logic          seg_tg_out,
  output logic [6:0]    seg,
  output logic [7:0]    cmd_count
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned GW = $clog2(CMD_GAP + 1);

  seq_state_e    state_q;
  logic [GW-1:0] gap_cnt_q;
  logic          wr_pend_q, sv_pend_q, sh_pend_q;
  logic          wr_req, sv_req, sh_req, any_req;

  assign wr_req  = write_btn | wr_pend_q;
  assign sv_req  = save_btn  | sv_pend_q;
  assign sh_req  = show_btn  | sh_pend_q;
  assign any_req = wr_req | sv_req | sh_req;

  // Unaccepted requests (including losers of arbitration in IDLE) stay pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      gap_cnt_q    <= '0;
      wr_pend_q    <= 1'b0;
      sv_pend_q    <= 1'b0;
      sh_pend_q    <= 1'b0;
      dp_write_en  <= 1'b0;
      dp_save_data <= 1'b0;
      dp_show_reg  <= 1'b0;
      dp_d_in      <= '0;
      busy         <= 1'b0;
    end else begin
      dp_write_en  <= 1'b0;
      dp_save_data <= 1'b0;
      wr_pend_q    <= wr_req;
      sv_pend_q    <= sv_req;
      sh_pend_q    <= sh_req;
      // Also covers the IDLE recovery cycle, so busy spans the full command spacing.
      busy         <= (state_q != StIdle) | any_req;
      unique case (state_q)
        StIdle: begin
          if (wr_req) begin
            state_q     <= StWrite;
            dp_d_in     <= d_in;
            dp_write_en <= 1'b1;
            wr_pend_q   <= 1'b0;
          end else if (sv_req) begin
            state_q      <= StSave;
            dp_save_data <= 1'b1;
            sv_pend_q    <= 1'b0;
          end else if (sh_req) begin
            state_q     <= StShow;
            dp_show_reg <= ~dp_show_reg;
            sh_pend_q   <= 1'b0;
          end
        end
        StWrite, StSave, StShow: begin
          state_q   <= StGap;
          gap_cnt_q <= '0;
        end
        StGap: begin
          if (gap_cnt_q == GW'(CMD_GAP - 1)) begin
            state_q <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic [TW-1:0] tick_q;
  logic [DW-1:0] latch_q;
  logic          wrap;
  logic          tg_next;
  logic [DW-1:0] latch_next;
  logic [3:0]    nibble;
  logic [6:0]    seg_dec;

  // seg is computed from the post-wrap digit select and latch so it always matches them.
  always_comb begin
    wrap       = (tick_q == TW'(TICK_DIV - 1));
    tg_next    = seg_tg_out ^ wrap;
    latch_next = (wrap && seg_tg_out) ? dp_d_out : latch_q;
    nibble     = tg_next ? latch_next[7:4] : latch_next[3:0];
  end

  hex_to_7seg u_hex_to_7seg (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q     <= '0;
      latch_q    <= '0;
      seg_tg_out <= 1'b0;
      seg        <= SEG_BLANK;
    end else if (wrap) begin
      tick_q     <= '0;
      latch_q    <= latch_next;
      seg_tg_out <= tg_next;
      seg        <= seg_dec;
    end else begin
      tick_q <= tick_q + 1'b1;
    end
  end

`ifdef CMD_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_count <= 8'h00;
    end else if (state_q inside {StWrite, StSave, StShow}) begin
      cmd_count <= cmd_count + 8'd1;
    end
  end
`else
  assign cmd_count = 8'h00;
`endif

endmodule
